// File: rtl/byte_mem_pkg.sv
// Shared types and defaults for the byte-wide memory port.
// Holds the control FSM state encoding, parameter defaults and the
// out-of-range read value.
package byte_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEPTH_DEF         = 4096;
    localparam int WAIT_CYCLES_DEF   = 2;
    localparam int PROTECT_LIMIT_DEF = 256;

    // Wait counter width covers the legal WAIT_CYCLES range 0..15.
    localparam int CNT_W = 4;

    localparam logic [7:0] OOR_READ_DATA = 8'hFF;

endpackage

// File: rtl/byte_mem_array.sv
// Single-port synchronous byte RAM backing the memory port.
// Latency: read data is registered, valid one edge after the address.
// No backpressure: a write is accepted on any edge with we_i high.
module byte_mem_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];

    // Read-first single port: write the addressed byte, register its old value.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/byte_mem_port.sv
// Byte memory port for a cache controller: latched request, wait-state FSM, tri-state data bus.
// Latency: MRDY rises WAIT_CYCLES+1 edges after leaving IDLE; MRDY/MERR are one-cycle pulses.
// No backpressure; a changed request aborts and restarts. BYTE_MEM_WRITE_PROTECT_EN enables write protect.
module byte_mem_port
    import byte_mem_pkg::*;
#(
    parameter int DEPTH         = DEPTH_DEF,
    parameter int WAIT_CYCLES   = WAIT_CYCLES_DEF,
    parameter int PROTECT_LIMIT = PROTECT_LIMIT_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] MADDR,
    input  logic        MWE,
    inout  wire  [7:0]  MD,
    output logic        MRDY,
    output logic        MERR
);

    localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic [31:0]      DEPTH_L = 32'(DEPTH);
    localparam logic [31:0]      PROT_L  = 32'(PROTECT_LIMIT);
`ifdef BYTE_MEM_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [31:0]      laddr_q, laddr_d;
    logic             lwe_q, lwe_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             mrdy_q, mrdy_d;
    logic             merr_q, merr_d;

    logic             req_chg;
    logic             in_range;
    logic             prot_hit;
    logic             reject;
    logic             commit;
    logic             ram_we;
    logic [7:0]       ram_rdata;

    // Request decode: change detection against the latch and access legality.
    always_comb begin
        req_chg  = (MADDR != laddr_q) || (MWE != lwe_q);
        in_range = (laddr_q < DEPTH_L);
        prot_hit = lwe_q && (laddr_q < PROT_L);
        reject   = !in_range || (PROT_EN && prot_hit);
        commit   = (state_q == ST_BUSY) && !req_chg && (cnt_q == '0);
        ram_we   = commit && lwe_q && !reject;
    end

    // Next-state and outputs: latch, count down, commit, pulse, return to idle.
    always_comb begin
        state_d = state_q;
        laddr_d = laddr_q;
        lwe_d   = lwe_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mrdy_d  = mrdy_q;
        merr_d  = merr_q;
        case (state_q)
            ST_IDLE: begin
                if (!valid_q || req_chg) begin
                    laddr_d = MADDR;
                    lwe_d   = MWE;
                    cnt_d   = WAIT_LD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (req_chg) begin
                    // Controller moved on: drop the pending access and restart.
                    laddr_d = MADDR;
                    lwe_d   = MWE;
                    cnt_d   = WAIT_LD;
                end else if (cnt_q == '0) begin
                    if (!lwe_q) begin
                        rdata_d = in_range ? ram_rdata : OOR_READ_DATA;
                    end
                    mrdy_d  = 1'b1;
                    merr_d  = reject;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                mrdy_d  = 1'b0;
                merr_d  = 1'b0;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers, cleared immediately by reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            laddr_q <= '0;
            lwe_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 8'h00;
            mrdy_q  <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            laddr_q <= laddr_d;
            lwe_q   <= lwe_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mrdy_q  <= mrdy_d;
            merr_q  <= merr_d;
        end
    end

    // The RAM is addressed with the next latched address so its registered
    // read data already holds storage[laddr] by the commit edge, even with
    // zero wait cycles.
    byte_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .addr_i  (laddr_d[AW-1:0]),
        .wdata_i (MD),
        .rdata_o (ram_rdata)
    );

    assign MD   = MWE ? 8'bzzzz_zzzz : rdata_q;
    assign MRDY = mrdy_q;
    assign MERR = merr_q;

endmodule
